// File: rtl/hilo_sequencer_pkg.sv
// Shared constants for the HI/LO sequencer: HI/LO funct codes, FSM state encodings
// and the HI/LO-op decode helper.
package hilo_sequencer_pkg;

    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_MUL   = 2'd1;
    localparam logic [1:0] ST_DIV   = 2'd2;
    localparam logic [1:0] ST_FIXUP = 2'd3;

    function automatic logic is_hilo_op(input logic [5:0] f);
        logic r;
        case (f)
            FUNCT_MFHI, FUNCT_MTHI, FUNCT_MFLO, FUNCT_MTLO,
            FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/muldiv_iterator.sv
// Unsigned iterative datapath: one shift-add multiply step or one restoring divide
// step per cycle on magnitudes loaded by hilo_sequencer; counts steps 0..31.
module muldiv_iterator (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic        step_i,
    input  logic        is_div_i,
    input  logic [31:0] op_a_i,
    input  logic [31:0] op_b_i,
    output logic        last_o,
    output logic [63:0] product_o,
    output logic [31:0] quotient_o,
    output logic [31:0] remainder_o
);

    logic [63:0] acc_q, acc_d;
    logic [63:0] sh_a_q, sh_a_d;
    logic [31:0] sh_b_q, sh_b_d;
    logic [5:0]  count_q, count_d;
    logic        div_q, div_d;

    logic [32:0] rem_shift;
    logic [33:0] diff;

    // Divide: shift the next dividend bit into the partial remainder, try subtracting.
    assign rem_shift = {acc_q[31:0], sh_a_q[31]};
    assign diff      = {1'b0, rem_shift} - {2'b00, sh_b_q};

    always_comb begin
        acc_d   = acc_q;
        sh_a_d  = sh_a_q;
        sh_b_d  = sh_b_q;
        count_d = count_q;
        div_d   = div_q;
        if (load_i) begin
            acc_d   = 64'd0;
            sh_a_d  = {32'd0, op_a_i};
            sh_b_d  = op_b_i;
            count_d = 6'd0;
            div_d   = is_div_i;
        end else if (step_i) begin
            count_d = count_q + 6'd1;
            if (div_q) begin
                if (!diff[33]) begin
                    acc_d  = {32'd0, diff[31:0]};
                    sh_a_d = {32'd0, sh_a_q[30:0], 1'b1};
                end else begin
                    acc_d  = {32'd0, rem_shift[31:0]};
                    sh_a_d = {32'd0, sh_a_q[30:0], 1'b0};
                end
            end else begin
                if (sh_b_q[0]) begin
                    acc_d = acc_q + sh_a_q;
                end
                sh_a_d = {sh_a_q[62:0], 1'b0};
                sh_b_d = {1'b0, sh_b_q[31:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q   <= 64'd0;
            sh_a_q  <= 64'd0;
            sh_b_q  <= 32'd0;
            count_q <= 6'd0;
            div_q   <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            sh_a_q  <= sh_a_d;
            sh_b_q  <= sh_b_d;
            count_q <= count_d;
            div_q   <= div_d;
        end
    end

    assign last_o      = (count_q == 6'd31);
    assign product_o   = acc_q;
    assign quotient_o  = sh_a_q[31:0];
    assign remainder_o = acc_q[31:0];

endmodule

// File: rtl/hilo_sequencer.sv
// HI/LO register pair and multiply/divide controller for the execute stage.
// Optional HILO_FAST_MULT_EN: single-cycle combinational multiply; divide stays iterative.
module hilo_sequencer
    import hilo_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        issue,
    input  logic [5:0]  funct,
    input  logic [31:0] rsData,
    input  logic [31:0] rtData,
    output logic        stall,
    output logic        busy,
    output logic [31:0] readData,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    logic [1:0]  state_q, state_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic        op_div_q, op_div_d;
    logic        neg_q, neg_d;
    logic        rem_neg_q, rem_neg_d;
    logic        dbz_q, dbz_d;

    logic        is_hilo, accept, is_signed, sign_a, sign_b;
    logic [31:0] mag_a, mag_b;
    logic        iter_load, iter_step, iter_last;
    logic [63:0] iter_prod, prod_fix;
    logic [31:0] iter_quo, iter_rem, quo_fix, rem_fix;

    // Handshake: an op is taken when issue && HI/LO op && !stall; stall holds it otherwise.
    assign is_hilo = is_hilo_op(funct);
    assign stall   = issue && is_hilo && (state_q != ST_IDLE);
    assign accept  = issue && is_hilo && !stall;
    assign busy    = (state_q != ST_IDLE);

    assign is_signed = (funct == FUNCT_MULT) || (funct == FUNCT_DIV);
    assign sign_a    = is_signed && rsData[31];
    assign sign_b    = is_signed && rtData[31];
    assign mag_a     = sign_a ? (32'd0 - rsData) : rsData;
    assign mag_b     = sign_b ? (32'd0 - rtData) : rtData;

    assign prod_fix = neg_q ? (64'd0 - iter_prod) : iter_prod;
    assign quo_fix  = neg_q ? (32'd0 - iter_quo) : iter_quo;
    assign rem_fix  = rem_neg_q ? (32'd0 - iter_rem) : iter_rem;

`ifdef HILO_FAST_MULT_EN
    logic [63:0] fast_mag, fast_prod;
    assign fast_mag  = {32'd0, mag_a} * {32'd0, mag_b};
    assign fast_prod = (sign_a ^ sign_b) ? (64'd0 - fast_mag) : fast_mag;
`endif

    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        op_div_d  = op_div_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        dbz_d     = dbz_q;
        iter_load = 1'b0;
        iter_step = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (funct)
                        FUNCT_MTHI: hi_d = rsData;
                        FUNCT_MTLO: lo_d = rsData;
                        FUNCT_MULT, FUNCT_MULTU: begin
`ifdef HILO_FAST_MULT_EN
                            hi_d = fast_prod[63:32];
                            lo_d = fast_prod[31:0];
`else
                            state_d   = ST_MUL;
                            iter_load = 1'b1;
                            op_div_d  = 1'b0;
                            neg_d     = sign_a ^ sign_b;
                            rem_neg_d = 1'b0;
                            dbz_d     = 1'b0;
`endif
                        end
                        FUNCT_DIV, FUNCT_DIVU: begin
                            state_d   = ST_DIV;
                            iter_load = 1'b1;
                            op_div_d  = 1'b1;
                            neg_d     = sign_a ^ sign_b;
                            rem_neg_d = sign_a;
                            dbz_d     = (rtData == 32'd0);
                        end
                        default: ;
                    endcase
                end
            end
            ST_MUL, ST_DIV: begin
                iter_step = 1'b1;
                if (iter_last) begin
                    state_d = ST_FIXUP;
                end
            end
            ST_FIXUP: begin
                // Divide by zero: quotient forced to all ones, remainder is the original rs.
                if (op_div_q) begin
                    lo_d = dbz_q ? 32'hFFFF_FFFF : quo_fix;
                    hi_d = rem_fix;
                end else begin
                    hi_d = prod_fix[63:32];
                    lo_d = prod_fix[31:0];
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            op_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            op_div_q  <= op_div_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            dbz_q     <= dbz_d;
        end
    end

    muldiv_iterator u_iter (
        .clk         (clk),
        .rst         (rst),
        .load_i      (iter_load),
        .step_i      (iter_step),
        .is_div_i    (op_div_d),
        .op_a_i      (mag_a),
        .op_b_i      (mag_b),
        .last_o      (iter_last),
        .product_o   (iter_prod),
        .quotient_o  (iter_quo),
        .remainder_o (iter_rem)
    );

    assign readData = !accept                ? 32'd0 :
                      (funct == FUNCT_MFHI)  ? hi_q  :
                      (funct == FUNCT_MFLO)  ? lo_q  : 32'd0;
    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: tb/tb_hilo_sequencer.sv
// Directed bench for hilo_sequencer: vector table of mult/div results plus
// hand-written stall, back-to-back, pass-through and mid-operation reset sequences.
module tb_hilo_sequencer;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_ADD   = 6'h20;

`ifdef HILO_FAST_MULT_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  typedef struct {
    logic [5:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue;
  logic [5:0]  funct;
  logic [31:0] rsData, rtData;
  logic        stall, busy;
  logic [31:0] readData, hi, lo;

  int checks = 0;
  int errors = 0;

  vec_t vecs[11];

  always #5 clk = ~clk;

  hilo_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .issue    (issue),
    .funct    (funct),
    .rsData   (rsData),
    .rtData   (rtData),
    .stall    (stall),
    .busy     (busy),
    .readData (readData),
    .hi       (hi),
    .lo       (lo)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Presents an op from just after a negedge, holds it through any stall, returns
  // at the negedge after the accepting edge with the stall count and readData seen.
  task automatic do_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       output int stalls, output logic [31:0] rd);
    issue = 1'b1; funct = f; rsData = a; rtData = b; stalls = 0;
    #1;
    while (stall && stalls < 100) begin
      @(negedge clk); #1;
      stalls++;
    end
    if (stall) begin
      checks++; errors++;
      $display("FAIL stall_timeout: funct 0x%02h still stalled after %0d cycles", f, stalls);
    end
    rd = readData;
    @(posedge clk); #1;
    issue = 1'b0; funct = 6'h00; rsData = 32'd0; rtData = 32'd0;
    @(negedge clk);
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (busy && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  function automatic bit is_mult(input logic [5:0] f);
    return (f == F_MULT) || (f == F_MULTU);
  endfunction

  initial begin
    int s, cyc, bad;
    logic [31:0] rd;
    logic [5:0] f;

    vecs[0]  = '{F_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[1]  = '{F_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[2]  = '{F_DIVU,  32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF};
    vecs[3]  = '{F_DIV,   32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF};
    vecs[4]  = '{F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[5]  = '{F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[6]  = '{F_DIV,   32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF};
    vecs[7]  = '{F_MULT,  32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001};
    vecs[8]  = '{F_DIVU,  32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E};
    vecs[9]  = '{F_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[10] = '{F_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};

    // Clock/reset
    rst = 1'b1; issue = 1'b0; funct = 6'h00; rsData = 32'd0; rtData = 32'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_stall", 32'(stall), 32'd0);
    check("reset_readdata", readData, 32'd0);
    @(negedge clk);

    // Single-cycle moves
    do_op(F_MTHI, 32'h1234_5678, 32'd0, s, rd);
    check("mthi_stall", 32'(s), 32'd0);
    check("mthi_hi", hi, 32'h1234_5678);
    do_op(F_MFHI, 32'd0, 32'd0, s, rd);
    check("mfhi_stall", 32'(s), 32'd0);
    check("mfhi_read", rd, 32'h1234_5678);
    do_op(F_MTLO, 32'hCAFE_F00D, 32'd0, s, rd);
    check("mtlo_lo", lo, 32'hCAFE_F00D);
    check("mtlo_hi_kept", hi, 32'h1234_5678);
    do_op(F_MFLO, 32'd0, 32'd0, s, rd);
    check("mflo_read", rd, 32'hCAFE_F00D);

    // Table of multiply/divide vectors
    for (int i = 0; i < 11; i++) begin
      do_op(vecs[i].f, vecs[i].a, vecs[i].b, s, rd);
      wait_idle(cyc);
      check($sformatf("vec%0d_busy_cycles", i), 32'(cyc),
            (FAST && is_mult(vecs[i].f)) ? 32'd0 : 32'd33);
      check($sformatf("vec%0d_hi", i), hi, vecs[i].exp_hi);
      check($sformatf("vec%0d_lo", i), lo, vecs[i].exp_lo);
    end

    // MFLO immediately behind a MULT stalls for the whole operation
    do_op(F_MULT, 32'hFFFF_FFFD, 32'h0000_0007, s, rd);
    do_op(F_MFLO, 32'd0, 32'd0, s, rd);
    check("mflo_behind_mult_stalls", 32'(s), FAST ? 32'd0 : 32'd33);
    check("mflo_behind_mult_read", rd, 32'hFFFF_FFEB);
    check("mflo_behind_mult_busy", 32'(busy), 32'd0);

    // Back-to-back MULTU then DIVU
    do_op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, s, rd);
    do_op(F_DIVU, 32'h0000_0064, 32'h0000_0007, s, rd);
    check("b2b_div_stalls", 32'(s), FAST ? 32'd0 : 32'd33);
    wait_idle(cyc);
    check("b2b_div_busy_cycles", 32'(cyc), 32'd33);
    check("b2b_div_hi", hi, 32'h0000_0002);
    check("b2b_div_lo", lo, 32'h0000_000E);

    // Non-HI/LO instruction during busy never stalls
    do_op(F_DIV, 32'hFFFF_FFF9, 32'h0000_0002, s, rd);
    bad = 0; cyc = 0;
    while (busy && cyc < 100) begin
      issue = 1'b1; funct = F_ADD; rsData = 32'h1; rtData = 32'h2;
      #1;
      if (stall) bad++;
      @(negedge clk);
      cyc++;
    end
    issue = 1'b0; funct = 6'h00;
    check("add_during_busy_stalls", 32'(bad), 32'd0);
    check("add_during_busy_cycles", 32'(cyc), 32'd33);
    check("add_during_busy_hi", hi, 32'hFFFF_FFFF);
    check("add_during_busy_lo", lo, 32'hFFFF_FFFD);

    // Reset at iteration 10 aborts the op and clears HI/LO
    f = FAST ? F_DIVU : F_MULTU;
    do_op(f, 32'hFFFF_FFFF, 32'hFFFF_FFFF, s, rd);
    repeat (10) @(negedge clk);
    check("midrst_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_hi", hi, 32'd0);
    check("midrst_lo", lo, 32'd0);
    @(negedge clk);
    check("midrst_stays_clear_lo", lo, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
